fp_decoder_unpack: RTL and testbench

- Unpacks a packed IEEE-754 word (FP64, or FP32 in bits [31:0]) into the FPU internal operand format: sign, 11-bit biased exponent, and 53-bit mantissa with the hidden bit at [52].
- Classifies the operand as zero, subnormal, inf, NaN or sNaN.
- Produces a normalized form: signed unbiased exponent and mantissa with a leading 1. Subnormals are normalized by a multi-cycle shifter.
- Sits at the FPU operand input, ahead of the arithmetic datapath. Valid/ready on both sides.

---
 rtl/fp_decoder_unpack.sv | 185 ++++++++++++++++++
 tb/tb_fp_decoder_unpack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_decoder_unpack.sv
// IEEE-754 operand unpacker: splits FP64/FP32 words into sign/exponent/mantissa,
// classifies them, and normalizes subnormals with a multi-cycle left shifter.
module fp_decoder_unpack #(
  parameter int SHIFT_PER_CYCLE = 1,
  parameter int NEXP_W          = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              fp_in,
  input  logic                     is_double_precision,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     dp_out,
  output logic                     sign_out,
  output logic [10:0]              exponent_out,
  output logic [52:0]              mantissa_out,
  output logic signed [NEXP_W-1:0] norm_exp,
  output logic [52:0]              norm_mant,
  output logic                     is_zero,
  output logic                     is_subnormal,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     is_snan
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     dp_q, dp_d;
  logic                     sign_q, sign_d;
  logic [10:0]              exp_q, exp_d;
  logic [52:0]              mant_q, mant_d;
  logic signed [NEXP_W-1:0] norm_exp_q, norm_exp_d;
  logic [52:0]              norm_mant_q, norm_mant_d;
  logic                     zero_q, zero_d;
  logic                     sub_q, sub_d;
  logic                     inf_q, inf_d;
  logic                     nan_q, nan_d;
  logic                     snan_q, snan_d;

  logic                     in_sign;
  logic [10:0]              in_exp;
  logic [51:0]              in_frac;
  logic signed [NEXP_W-1:0] in_bias;
  logic                     in_exp_max;
  logic                     exp_zero;
  logic                     frac_zero;
  logic                     accept;
  logic [5:0]               lz;
  logic [5:0]               shift_amt;
  logic [52:0]              shifted_mant;

  // Field extraction for the precision selected alongside the incoming word
  always_comb begin
    if (is_double_precision) begin
      in_sign    = fp_in[63];
      in_exp     = fp_in[62:52];
      in_frac    = fp_in[51:0];
      in_bias    = NEXP_W'(1023);
      in_exp_max = &fp_in[62:52];
    end else begin
      in_sign    = fp_in[31];
      in_exp     = {3'b000, fp_in[30:23]};
      in_frac    = {fp_in[22:0], 29'b0};
      in_bias    = NEXP_W'(127);
      in_exp_max = &fp_in[30:23];
    end
  end

  assign exp_zero  = (in_exp == 11'd0);
  assign frac_zero = (in_frac == 52'd0);

  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  // Ascending scan so the highest set bit determines the final count
  always_comb begin
    lz = 6'd53;
    for (int i = 0; i <= 52; i++) begin
      if (norm_mant_q[i]) lz = 6'(52 - i);
    end
  end

  assign shift_amt    = (lz < 6'(SHIFT_PER_CYCLE)) ? lz : 6'(SHIFT_PER_CYCLE);
  assign shifted_mant = norm_mant_q << shift_amt;

  always_comb begin
    state_d     = state_q;
    dp_d        = dp_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    norm_exp_d  = norm_exp_q;
    norm_mant_d = norm_mant_q;
    zero_d      = zero_q;
    sub_d       = sub_q;
    inf_d       = inf_q;
    nan_d       = nan_q;
    snan_d      = snan_q;

    case (state_q)
      NORM: begin
        norm_mant_d = shifted_mant;
        norm_exp_d  = norm_exp_q - NEXP_W'(shift_amt);
        if (shifted_mant[52]) state_d = DONE;
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    // A new operand overrides whatever the current state would have done
    if (accept) begin
      dp_d   = is_double_precision;
      sign_d = in_sign;
      exp_d  = in_exp;
      mant_d = {!exp_zero, in_frac};
      zero_d = exp_zero && frac_zero;
      sub_d  = exp_zero && !frac_zero;
      inf_d  = in_exp_max && frac_zero;
      nan_d  = in_exp_max && !frac_zero;
      snan_d = in_exp_max && !frac_zero && !in_frac[51];
      if (exp_zero && frac_zero) begin
        norm_mant_d = 53'd0;
        norm_exp_d  = '0;
        state_d     = DONE;
      end else if (exp_zero) begin
        norm_mant_d = {1'b0, in_frac};
        norm_exp_d  = NEXP_W'(1) - in_bias;
        state_d     = NORM;
      end else begin
        norm_mant_d = {1'b1, in_frac};
        norm_exp_d  = NEXP_W'(in_exp) - in_bias;
        state_d     = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dp_q        <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 11'd0;
      mant_q      <= 53'd0;
      norm_exp_q  <= '0;
      norm_mant_q <= 53'd0;
      zero_q      <= 1'b0;
      sub_q       <= 1'b0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
      snan_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_q        <= dp_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      norm_exp_q  <= norm_exp_d;
      norm_mant_q <= norm_mant_d;
      zero_q      <= zero_d;
      sub_q       <= sub_d;
      inf_q       <= inf_d;
      nan_q       <= nan_d;
      snan_q      <= snan_d;
    end
  end

  assign dp_out       = dp_q;
  assign sign_out     = sign_q;
  assign exponent_out = exp_q;
  assign mantissa_out = mant_q;
  assign norm_exp     = norm_exp_q;
  assign norm_mant    = norm_mant_q;
  assign is_zero      = zero_q;
  assign is_subnormal = sub_q;
  assign is_inf       = inf_q;
  assign is_nan       = nan_q;
  assign is_snan      = snan_q;

endmodule

// File: tb/tb_fp_decoder_unpack.sv
// Randomized bench for fp_decoder_unpack, compared against an arithmetic model
// of IEEE-754 unpacking and normalization.
module tb_fp_decoder_unpack;

   localparam int SPC = 8;
   localparam int NW  = 13;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [63:0]      fpIn = '0;
   logic             dpIn = 1'b0;
   logic             outValid;
   logic             outReady = 1'b1;
   logic             dpOut, signOut;
   logic [10:0]      exponentOut;
   logic [52:0]      mantissaOut, normMant;
   logic signed [NW-1:0] normExp;
   logic             isZero, isSubnormal, isInf, isNan, isSnan;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic        dp;
      logic        sign;
      logic [10:0] expo;
      logic [52:0] mant;
      logic [52:0] nMant;
      int          nExp;
      logic [4:0]  flags;
      int          lat;
   } expect_t;

   fp_decoder_unpack #(.SHIFT_PER_CYCLE(SPC), .NEXP_W(NW)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
      .fp_in(fpIn), .is_double_precision(dpIn), .out_valid(outValid),
      .out_ready(outReady), .dp_out(dpOut), .sign_out(signOut),
      .exponent_out(exponentOut), .mantissa_out(mantissaOut),
      .norm_exp(normExp), .norm_mant(normMant), .is_zero(isZero),
      .is_subnormal(isSubnormal), .is_inf(isInf), .is_nan(isNan),
      .is_snan(isSnan)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Safety net so a wedged design can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: decode from the IEEE rules, normalize subnormals by doubling
   function automatic expect_t refModel(input logic [63:0] fp, input logic dp);
      expect_t r;
      logic [51:0] frac;
      logic [52:0] m;
      int e, bias, allOnes, k;
      if (dp) begin
         r.sign = fp[63]; e = int'(fp[62:52]); frac = fp[51:0];
         bias = 1023; allOnes = 2047;
      end else begin
         r.sign = fp[31]; e = int'(fp[30:23]); frac = {fp[22:0], 29'b0};
         bias = 127; allOnes = 255;
      end
      r.dp   = dp;
      r.expo = 11'(e);
      r.mant = {(e != 0), frac};
      r.flags = {(e == 0 && frac == 0), (e == 0 && frac != 0),
                 (e == allOnes && frac == 0), (e == allOnes && frac != 0),
                 (e == allOnes && frac != 0 && !frac[51])};
      r.lat = 1;
      if (e == 0 && frac == 0) begin
         r.nMant = '0; r.nExp = 0;
      end else if (e == 0) begin
         m = {1'b0, frac}; k = 0;
         while (m < 53'h10000000000000) begin m = m * 2; k++; end
         r.nMant = m;
         r.nExp  = 1 - bias - k;
         r.lat   = 1 + (k + SPC - 1) / SPC;
      end else begin
         r.nMant = {1'b1, frac};
         r.nExp  = e - bias;
      end
      return r;
   endfunction

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Compare every decoded output against one model result
   task automatic checkResult(input expect_t r, input string tag);
      checkOutput({tag, "_dp"},    64'(dpOut), 64'(r.dp));
      checkOutput({tag, "_sign"},  64'(signOut), 64'(r.sign));
      checkOutput({tag, "_exp"},   64'(exponentOut), 64'(r.expo));
      checkOutput({tag, "_mant"},  64'(mantissaOut), 64'(r.mant));
      checkOutput({tag, "_nmant"}, 64'(normMant), 64'(r.nMant));
      checkOutput({tag, "_nexp"},  64'(normExp), 64'(NW'(r.nExp)));
      checkOutput({tag, "_flags"}, 64'({isZero, isSubnormal, isInf, isNan, isSnan}), 64'(r.flags));
   endtask

   // One full transaction from IDLE: accept, time the latency, check, drain
   task automatic applyStimulus(input logic [63:0] fp, input logic dp, input string tag);
      expect_t r;
      int lat;
      r = refModel(fp, dp);
      @(negedge clk);
      fpIn = fp; dpIn = dp; inValid = 1'b1; outReady = 1'b1;
      checkOutput({tag, "_in_ready"}, 64'(inReady), 64'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      fpIn = {$urandom(), $urandom()};
      lat = 1;
      while (!outValid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(r.lat));
      checkResult(r, tag);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] w;
      logic [63:0] words [4];
      logic        dp;
      int          cls, sh, stray;
      expect_t     r;

      // Reset values are visible while reset is still held
      #1;
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_mant", 64'(mantissaOut | normMant), 64'd0);
      checkOutput("rst_misc", 64'({dpOut, signOut, exponentOut, normExp,
                                   isZero, isSubnormal, isInf, isNan, isSnan}), 64'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      applyStimulus(64'h3FF0000000000000, 1'b1, "fp64_one");
      checkOutput("fp64_one_exp_lit", 64'(exponentOut), 64'h3FF);
      checkOutput("fp64_one_mant_lit", 64'(mantissaOut), 64'h10000000000000);
      checkOutput("fp64_one_nexp_lit", 64'(normExp), 64'd0);

      applyStimulus(64'h00000000C0000000, 1'b0, "fp32_m2");
      checkOutput("fp32_m2_exp_lit", 64'(exponentOut), 64'h080);
      checkOutput("fp32_m2_nexp_lit", 64'(normExp), 64'd1);

      applyStimulus(64'h1, 1'b1, "fp64_minsub");
      checkOutput("minsub_nexp_lit", 64'(normExp), 64'(NW'(-1074)));
      checkOutput("minsub_nmant_lit", 64'(normMant), 64'h10000000000000);

      applyStimulus(64'h7F800001, 1'b0, "fp32_snan");
      checkOutput("snan_mant_lit", 64'(mantissaOut), 64'h10000020000000);
      checkOutput("snan_flag_lit", 64'(isSnan), 64'd1);
      applyStimulus(64'h7FC00000, 1'b0, "fp32_qnan");
      checkOutput("qnan_flag_lit", 64'(isSnan), 64'd0);
      applyStimulus(64'h0, 1'b1, "fp64_zero");
      applyStimulus(64'hFFF0000000000000, 1'b1, "fp64_ninf");
      applyStimulus(64'h000FFFFFFFFFFFFF, 1'b1, "fp64_maxsub");
      applyStimulus(64'h00000001, 1'b0, "fp32_minsub");

      // Backpressure: result must hold and input side must stay closed
      r = refModel(64'h4009_21FB_5444_2D18, 1'b1);
      @(negedge clk);
      fpIn = 64'h4009_21FB_5444_2D18; dpIn = 1'b1; inValid = 1'b1; outReady = 1'b0;
      @(posedge clk); #1;
      fpIn = 64'hC000_0000_0000_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_out_valid", 64'(outValid), 64'd1);
         checkOutput("bp_in_ready", 64'(inReady), 64'd0);
         checkOutput("bp_nmant", 64'(normMant), 64'(r.nMant));
         checkOutput("bp_exp", 64'(exponentOut), 64'(r.expo));
      end

      // Streaming: one result per cycle, in order, round-tripping to the input
      for (int i = 0; i < 4; i++) begin
         words[i] = {1'($urandom()), 11'($urandom_range(1, 2046)), 52'({$urandom(), $urandom()})};
      end
      outReady = 1'b1; fpIn = words[0];
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         r = refModel(words[i-1], 1'b1);
         checkOutput("st_out_valid", 64'(outValid), 64'd1);
         checkOutput("st_in_ready", 64'(inReady), 64'd1);
         checkOutput("st_roundtrip", {signOut, exponentOut, mantissaOut[51:0]}, words[i-1]);
         checkResult(r, "st");
         if (i < 4) fpIn = words[i];
         else inValid = 1'b0;
      end
      @(posedge clk); #1;

      // Reset in the middle of a normalization discards the operation
      @(negedge clk);
      fpIn = 64'h1; dpIn = 1'b1; inValid = 1'b1; outReady = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
      checkOutput("midrst_in_ready", 64'(inReady), 64'd1);
      checkOutput("midrst_mant", 64'(mantissaOut | normMant), 64'd0);
      checkOutput("midrst_misc", 64'({dpOut, signOut, exponentOut, normExp,
                                      isZero, isSubnormal, isInf, isNan, isSnan}), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (outValid) stray++;
      end
      checkOutput("midrst_no_valid", 64'(stray), 64'd0);
      applyStimulus(64'h3FF8000000000000, 1'b1, "post_rst");

      // Random operands biased towards zero/subnormal and all-ones exponents
      for (int n = 0; n < 250; n++) begin
         w   = {$urandom(), $urandom()};
         dp  = 1'($urandom());
         cls = $urandom_range(0, 3);
         sh  = $urandom_range(0, 60);
         if (dp) begin
            w[51:0] = w[51:0] >> sh;
            if (cls == 0) w[62:52] = '0;
            else if (cls == 1) w[62:52] = '1;
         end else begin
            w[22:0] = w[22:0] >> sh;
            if (cls == 0) w[30:23] = '0;
            else if (cls == 1) w[30:23] = '1;
         end
         applyStimulus(w, dp, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
